// File: rtl/neuron_ctrl_pkg.sv
// Shared types and constants for the neuron training sequencer.
package neuron_ctrl_pkg;

  localparam int unsigned ERR_W = 16;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned Q_W   = 16;

  localparam logic [Q_W-1:0] ONE_Q88 = 16'h0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_SETTLE,
    S_LEARN,
    S_EPOCH_END,
    S_DONE
  } state_t;

  // XOR training target in Q8.8 for a 2-bit sample.
  function automatic logic [Q_W-1:0] xor_target(input logic [1:0] s);
    return (s[0] ^ s[1]) ? ONE_Q88 : '0;
  endfunction

endpackage

// File: rtl/abs_err_accum.sv
// Absolute error |expected - net_out| with saturating 24-bit accumulation.
module abs_err_accum
  import neuron_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [Q_W-1:0]   expected,
  input  logic [Q_W-1:0]   net_out,
  output logic [ACC_W-1:0] acc
);

  localparam int unsigned DIFF_W = Q_W + 1;
  localparam int unsigned SUM_W  = ACC_W + 1;

  logic signed [DIFF_W-1:0] diff_c;
  logic        [ERR_W-1:0]  abs_err_c;
  logic        [SUM_W-1:0]  sum_c;

  // Sign-extended difference; 17 bits hold the full range so |-32768| = 32768.
  always_comb begin
    diff_c    = $signed({expected[Q_W-1], expected}) - $signed({net_out[Q_W-1], net_out});
    abs_err_c = diff_c[DIFF_W-1] ? ERR_W'(-diff_c) : ERR_W'(diff_c);
    sum_c     = {1'b0, acc} + SUM_W'(abs_err_c);
  end

  // Accumulator register: clear has priority, carry-out saturates to all ones.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/training_sequencer.sv
// Epoch/sample sequencer driving XOR training of a small neuron network.
module training_sequencer
  import neuron_ctrl_pkg::*;
#(
  parameter int unsigned N_SAMPLES  = 4,
  parameter int unsigned FWD_LAT    = 2,
  parameter int unsigned MAX_EPOCHS = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] err_thresh,
  input  logic [Q_W-1:0]   net_out,
  output logic [1:0]       sample_in,
  output logic [31:0]      enabled,
  output logic [Q_W-1:0]   expected,
  output logic             learn_pulse,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic [15:0]      epoch_cnt,
  output logic [ACC_W-1:0] epoch_err
);

  localparam int unsigned IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int unsigned CNT_W = (FWD_LAT > 1) ? $clog2(FWD_LAT) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(FWD_LAT - 1);
  localparam logic [15:0]      EPOCH_LAST = 16'(MAX_EPOCHS - 1);
  localparam logic [31:0]      EN_MASK    = 32'h0000_0003;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] settle_cnt;
  logic [ACC_W-1:0] acc;
  logic             acc_clr_c;
  logic             acc_en_c;

  // Target follows the presented sample directly.
  assign expected = xor_target(sample_in);

  // Accumulator is idle-cleared and restarted at each epoch boundary after being read.
  assign acc_clr_c = (state == S_IDLE) || (state == S_EPOCH_END);
  assign acc_en_c  = (state == S_SETTLE) && (settle_cnt == '0) && !stop;

  abs_err_accum u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr_c),
    .en       (acc_en_c),
    .expected (expected),
    .net_out  (net_out),
    .acc      (acc)
  );

  // Sequencer FSM with registered outputs; stop pre-empts every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      settle_cnt  <= '0;
      sample_in   <= '0;
      enabled     <= '0;
      learn_pulse <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      epoch_cnt   <= '0;
      epoch_err   <= '0;
    end else begin
      learn_pulse <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        enabled <= '0;
        done    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              idx       <= '0;
              sample_in <= '0;
              epoch_cnt <= '0;
              epoch_err <= '0;
              done      <= 1'b0;
              converged <= 1'b0;
              busy      <= 1'b1;
              enabled   <= EN_MASK;
              state     <= S_PRESENT;
            end
          end
          S_PRESENT: begin
            settle_cnt <= SETTLE_LD;
            state      <= S_SETTLE;
          end
          S_SETTLE: begin
            if (settle_cnt == '0) begin
              learn_pulse <= 1'b1;
              state       <= S_LEARN;
            end else begin
              settle_cnt <= settle_cnt - CNT_W'(1);
            end
          end
          S_LEARN: begin
            if (idx == IDX_LAST) begin
              state <= S_EPOCH_END;
            end else begin
              idx       <= idx + IDX_W'(1);
              sample_in <= 2'(idx + IDX_W'(1));
              state     <= S_PRESENT;
            end
          end
          S_EPOCH_END: begin
            epoch_err <= acc;
            epoch_cnt <= epoch_cnt + 16'd1;
            if (acc <= err_thresh) begin
              converged <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              enabled   <= '0;
              state     <= S_DONE;
            end else if (epoch_cnt == EPOCH_LAST) begin
              converged <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              enabled   <= '0;
              state     <= S_DONE;
            end else begin
              idx       <= '0;
              sample_in <= '0;
              state     <= S_PRESENT;
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_training_sequencer.sv
// Self-checking bench for training_sequencer against an epoch-level reference model.
module tb_training_sequencer;

  localparam int N_SAMPLES   = 4;
  localparam int FWD_LAT     = 2;
  localparam int MAX_EPOCHS  = 1000;
  localparam int SAMPLE_CYC  = 2 + FWD_LAT;
  localparam int EPOCH_CYC   = N_SAMPLES * SAMPLE_CYC + 1;
  localparam int SAT         = 16777215;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [23:0] err_thresh;
  logic [15:0] net_out;
  logic [1:0]  sample_in;
  logic [31:0] enabled;
  logic [15:0] expected;
  logic        learn_pulse;
  logic        busy;
  logic        done;
  logic        converged;
  logic [15:0] epoch_cnt;
  logic [23:0] epoch_err;

  int checks;
  int errors;

  training_sequencer #(
    .N_SAMPLES  (N_SAMPLES),
    .FWD_LAT    (FWD_LAT),
    .MAX_EPOCHS (MAX_EPOCHS)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .err_thresh  (err_thresh),
    .net_out     (net_out),
    .sample_in   (sample_in),
    .enabled     (enabled),
    .expected    (expected),
    .learn_pulse (learn_pulse),
    .busy        (busy),
    .done        (done),
    .converged   (converged),
    .epoch_cnt   (epoch_cnt),
    .epoch_err   (epoch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // XOR target of sample s in Q8.8: 256 when exactly one input bit is set.
  function automatic int target(input int s);
    return ((s % 2) != (s / 2)) ? 256 : 0;
  endfunction

  // Network output the environment produces for sample s in a given mode.
  function automatic logic [15:0] net_model(input int mode, input int s);
    case (mode)
      0:       return 16'h0100;
      1:       return 16'(target(s));
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Sum of absolute errors over one epoch, saturated to 24 bits.
  function automatic int epoch_sum(input logic [15:0] tab [N_SAMPLES]);
    int sum;
    int d;
    sum = 0;
    for (int s = 0; s < N_SAMPLES; s++) begin
      d = target(s) - int'($signed(tab[s]));
      if (d < 0) d = -d;
      sum += d;
      if (sum > SAT) sum = SAT;
    end
    return sum;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_sample"},   32'(sample_in),   32'd0);
    check({tag, "_enabled"},  enabled,          32'd0);
    check({tag, "_learn"},    32'(learn_pulse), 32'd0);
    check({tag, "_busy"},     32'(busy),        32'd0);
    check({tag, "_done"},     32'(done),        32'd0);
    check({tag, "_conv"},     32'(converged),   32'd0);
    check({tag, "_ecnt"},     32'(epoch_cnt),   32'd0);
    check({tag, "_eerr"},     32'(epoch_err),   32'd0);
    check({tag, "_expected"}, 32'(expected),    32'd0);
  endtask

  // One training session; stop_cyc/rst_cyc (1-based cycles after acceptance) abort it when non-zero.
  task automatic run_train(input int mode, input logic [23:0] thr, input bit hold_start,
                           input int stop_cyc, input int rst_cyc);
    logic [15:0] tab [N_SAMPLES];
    int sum;
    int prev_sum;
    int c;
    int e;
    bit fin;
    bit conv;
    c        = 0;
    e        = 0;
    fin      = 1'b0;
    conv     = 1'b0;
    prev_sum = 0;
    err_thresh = thr;
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b0;
    while (!fin) begin
      for (int s = 0; s < N_SAMPLES; s++) tab[s] = net_model(mode, s);
      sum = epoch_sum(tab);
      for (int pos = 0; pos < EPOCH_CYC; pos++) begin
        @(negedge clk);
        c++;
        if (!hold_start) start = 1'b0;
        check("busy",    32'(busy), 32'd1);
        check("enabled", enabled,   32'h3);
        check("done",    32'(done), 32'd0);
        if (pos < EPOCH_CYC - 1) begin
          check("sample_in", 32'(sample_in),   32'(pos / SAMPLE_CYC));
          check("expected",  32'(expected),    32'(target(pos / SAMPLE_CYC)));
          check("learn",     32'(learn_pulse), 32'((pos % SAMPLE_CYC) == SAMPLE_CYC - 1));
        end else begin
          check("learn_eoe", 32'(learn_pulse), 32'd0);
        end
        if (pos == 0) begin
          check("ecnt_run", 32'(epoch_cnt), 32'(e));
          check("eerr_run", 32'(epoch_err), 32'(prev_sum));
        end
        if (c == stop_cyc) begin
          stop = 1'b1;
          @(negedge clk);
          check("stop_busy",    32'(busy),        32'd0);
          check("stop_done",    32'(done),        32'd0);
          check("stop_learn",   32'(learn_pulse), 32'd0);
          check("stop_enabled", enabled,          32'd0);
          stop  = 1'b0;
          start = 1'b0;
          repeat (SAMPLE_CYC * 2) begin
            @(negedge clk);
            check("idle_learn", 32'(learn_pulse), 32'd0);
            check("idle_busy",  32'(busy),        32'd0);
          end
          return;
        end
        if (c == rst_cyc) begin
          rst_n = 1'b0;
          @(negedge clk);
          check_all_zero("rst_mid");
          rst_n = 1'b1;
          start = 1'b0;
          return;
        end
        if (pos < EPOCH_CYC - 1) net_out = tab[pos / SAMPLE_CYC];
      end
      prev_sum = sum;
      e++;
      if (sum <= int'(thr)) begin
        fin  = 1'b1;
        conv = 1'b1;
      end else if (e == MAX_EPOCHS) begin
        fin = 1'b1;
      end
    end
    @(negedge clk);
    check("fin_done",    32'(done),        32'd1);
    check("fin_busy",    32'(busy),        32'd0);
    check("fin_enabled", enabled,          32'd0);
    check("fin_learn",   32'(learn_pulse), 32'd0);
    check("fin_conv",    32'(converged),   32'(conv));
    check("fin_ecnt",    32'(epoch_cnt),   32'(e));
    check("fin_eerr",    32'(epoch_err),   32'(prev_sum));
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("done_hold", 32'(done),      32'd1);
      check("done_busy", 32'(busy),      32'd0);
      check("done_ecnt", 32'(epoch_cnt), 32'(e));
    end
    start = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    check("exit_done", 32'(done), 32'd0);
    check("exit_busy", 32'(busy), 32'd0);
    stop = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    err_thresh = '0;
    net_out    = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // start and stop together in IDLE: stop wins
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("both_busy",  32'(busy),        32'd0);
      check("both_learn", 32'(learn_pulse), 32'd0);
    end
    start = 1'b0;
    stop  = 1'b0;

    run_train(0, 24'h000000, 1'b0, 0, 0);
    run_train(1, 24'h000000, 1'b1, 0, 0);
    run_train(2, 24'hFFFFFF, 1'b0, 0, 0);
    run_train(0, 24'h000000, 1'b0, 2 * SAMPLE_CYC + 2, 0);
    run_train(1, 24'h000000, 1'b0, 0, SAMPLE_CYC + FWD_LAT + 1);
    run_train(1, 24'h000000, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_train(3, 24'($urandom_range(90000, 140000)), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
